// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: control/display bundle between the scan controller and its user
//   en          scan enable (low = dark and parked)
//   blank_mask  bit i forces digit i dark
//   blink_mask  bit i darkens digit i during blink-off half-period
//   sel         nibble select to the hex display mux
//   an          active-low digit anodes
//   frame_tick  one-cycle pulse on the last cycle of each frame
//   blink_phase 0 = blink-on, 1 = blink-off half-period
interface digit_scan_ctrl_if;
  logic       en;
  logic [3:0] blank_mask;
  logic [3:0] blink_mask;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame_tick;
  logic       blink_phase;
  modport master (output en, blank_mask, blink_mask, input sel, an, frame_tick, blink_phase);
  modport slave  (input en, blank_mask, blink_mask, output sel, an, frame_tick, blink_phase);
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: four-digit seven-segment scan with dead-time, blanking and frame-synchronous blink
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    digit_scan_ctrl_if.slave (en/masks in; sel/an/frame_tick/blink_phase out, all registered)
module digit_scan_ctrl #(
  parameter int DIV          = 100000,
  parameter int DEAD         = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic             clk,
  input  logic             rst_n,
  digit_scan_ctrl_if.slave bus
);
  localparam int SW = DIV > 2 ? $clog2(DIV) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
  localparam logic [SW-1:0] DEAD_V     = SW'(DEAD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q, an_d;
  logic          frame_tick_q, frame_tick_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          keep_run, slot_wrap, blink_wrap, lit;
  // All outputs are derived from next-state values so sel, an and frame_tick always describe the same slot.
  always_comb begin
    keep_run      = state_q == RUN && bus.en;
    slot_wrap     = slot_q == SLOT_LAST;
    state_d       = bus.en ? RUN : IDLE;
    slot_d        = keep_run ? (slot_wrap ? '0 : slot_q + 1'b1) : '0;
    sel_d         = keep_run ? (slot_wrap ? sel_q + 2'd1 : sel_q) : 2'd0;
    frame_tick_d  = state_d == RUN && sel_d == 2'd3 && slot_d == SLOT_LAST;
    // The tick being counted is the one currently on the output, so an abort on that cycle still counts it.
    blink_wrap    = blink_cnt_q == BLINK_LAST;
    blink_cnt_d   = frame_tick_q ? (blink_wrap ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
    blink_phase_d = blink_phase_q ^ (frame_tick_q && blink_wrap);
    lit           = state_d == RUN && slot_d >= DEAD_V && !bus.blank_mask[sel_d] &&
                    !(bus.blink_mask[sel_d] && blink_phase_d);
    an_d          = lit ? ~(4'b0001 << sel_d) : 4'b1111;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      sel_q         <= 2'd0;
      an_q          <= 4'b1111;
      frame_tick_q  <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sel_q         <= sel_d;
      an_q          <= an_d;
      frame_tick_q  <= frame_tick_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
  assign bus.sel         = sel_q;
  assign bus.an          = an_q;
  assign bus.frame_tick  = frame_tick_q;
  assign bus.blink_phase = blink_phase_q;
endmodule
